// File: rtl/i2c_target_regfile.sv
// I2C target bridging an open-drain SCL/SDA bus to an external byte-wide register bank.
// Latency: pins reach the FSM after SYNC_STAGES+1 clk_400 cycles; reg_wr_en follows the 8th data scl_rise by one cycle.
// Backpressure: none; SCL is never stretched, and NACK plus a return to bus-idle is the only refusal.
module i2c_target_regfile #(
    parameter logic [6:0] TARGET_ADDR = 7'h01,
    parameter int         NUM_REGS    = 16,
    parameter int         PTR_W       = $clog2(NUM_REGS),
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk_400,
    input  logic             rst_n,
    input  logic             SCL,
    inout  wire              SDA,
    output logic             reg_wr_en,
    output logic [PTR_W-1:0] reg_wr_addr,
    output logic [7:0]       reg_wr_data,
    output logic [PTR_W-1:0] reg_rd_addr,
    input  logic [7:0]       reg_rd_data,
    output logic             busy,
    output logic             done,
    output logic             ack_error,
    output logic [3:0]       state_out
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WR_DATA   = 4'd5,
        WR_ACK    = 4'd6,
        RD_DATA   = 4'd7,
        RD_ACK    = 4'd8,
        WAIT_STOP = 4'd9
    } state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_d, sda_d;
    logic [7:0]             shift;
    logic [6:0]             tx_sh;      // remaining read bits; the bit on the wire is not kept here
    logic [2:0]             bit_cnt;
    logic                   byte_rdy;   // 8 bits received, waiting for the scl_fall that opens the ACK slot
    logic                   rw;
    logic [PTR_W-1:0]       ptr;
    logic                   sda_low, sda_low_nxt;

    wire scl_s     = scl_sync[SYNC_STAGES-1];
    wire sda_s     = sda_sync[SYNC_STAGES-1];
    wire scl_rise  = scl_s & ~scl_d;
    wire scl_fall  = ~scl_s & scl_d;
    wire start_det = scl_s & sda_d & ~sda_s;
    wire stop_det  = scl_s & ~sda_d & sda_s;

    wire [7:0] byte_in  = {shift[6:0], sda_s};
    wire       addr_hit = (shift[7:1] == TARGET_ADDR);
    wire       ptr_ok   = ({1'b0, shift} < 9'(NUM_REGS));
    wire       rx_state = (state == ADDR) || (state == PTR) || (state == WR_DATA);

    assign SDA         = sda_low ? 1'b0 : 1'bz;
    assign reg_rd_addr = ptr;
    assign state_out   = state;

    // Pin synchronisers plus one delay flop for edge detection; reset to the idle-bus level
    always_ff @(posedge clk_400) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk_400) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state: bus conditions override everything, otherwise advance on SCL edges
    always_comb begin
        state_nxt = state;
        if (start_det) begin
            state_nxt = ADDR;
        end else if (stop_det) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                ADDR:     if (scl_fall && byte_rdy) state_nxt = addr_hit ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK: if (scl_fall) state_nxt = rw ? RD_DATA : PTR;
                PTR:      if (scl_fall && byte_rdy) state_nxt = ptr_ok ? PTR_ACK : WAIT_STOP;
                PTR_ACK:  if (scl_fall) state_nxt = WR_DATA;
                WR_DATA:  if (scl_fall && byte_rdy) state_nxt = WR_ACK;
                WR_ACK:   if (scl_fall) state_nxt = WR_DATA;
                RD_DATA:  if (scl_fall && bit_cnt == 3'd0) state_nxt = RD_ACK;
                RD_ACK: begin
                    if (scl_rise && sda_s) state_nxt = WAIT_STOP;
                    else if (scl_fall)     state_nxt = RD_DATA;
                end
                default: ;
            endcase
        end
    end

    // SDA drive decision: only moves on scl_fall so data never changes while SCL is high
    always_comb begin
        sda_low_nxt = sda_low;
        if (start_det || stop_det) begin
            sda_low_nxt = 1'b0;
        end else if (scl_fall) begin
            case (state)
                ADDR:     if (byte_rdy) sda_low_nxt = addr_hit;
                ADDR_ACK: sda_low_nxt = rw & ~reg_rd_data[7];
                PTR:      if (byte_rdy) sda_low_nxt = ptr_ok;
                WR_DATA:  if (byte_rdy) sda_low_nxt = 1'b1;
                RD_DATA:  sda_low_nxt = (bit_cnt != 3'd0) & ~tx_sh[6];
                RD_ACK:   sda_low_nxt = ~reg_rd_data[7];
                default:  sda_low_nxt = 1'b0;
            endcase
        end
    end

    // Registered open-drain enable
    always_ff @(posedge clk_400) begin
        if (!rst_n) sda_low <= 1'b0;
        else        sda_low <= sda_low_nxt;
    end

    // Datapath: shifting, pointer, write strobe and status flags
    always_ff @(posedge clk_400) begin
        if (!rst_n) begin
            shift       <= 8'd0;
            tx_sh       <= 7'd0;
            bit_cnt     <= 3'd7;
            byte_rdy    <= 1'b0;
            rw          <= 1'b0;
            ptr         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ack_error   <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= 8'd0;
        end else begin
            reg_wr_en <= 1'b0;
            done      <= 1'b0;
            if (start_det) begin
                shift     <= 8'd0;
                bit_cnt   <= 3'd7;
                byte_rdy  <= 1'b0;
                ack_error <= 1'b0;
            end else if (stop_det) begin
                bit_cnt  <= 3'd7;
                byte_rdy <= 1'b0;
                if (busy) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else begin
                if (rx_state && scl_rise && !byte_rdy) begin
                    shift <= byte_in;
                    if (bit_cnt == 3'd0) begin
                        byte_rdy <= 1'b1;
                        if (state == WR_DATA) begin
                            reg_wr_en   <= 1'b1;
                            reg_wr_addr <= ptr;
                            reg_wr_data <= byte_in;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 3'd1;
                    end
                end
                if (rx_state && scl_fall && byte_rdy) begin
                    byte_rdy <= 1'b0;
                    bit_cnt  <= 3'd7;
                    if (state == ADDR && addr_hit) begin
                        busy <= 1'b1;
                        rw   <= shift[0];
                    end
                    if (state == PTR && ptr_ok) ptr <= shift[PTR_W-1:0];
                end
                case (state)
                    ADDR_ACK: if (scl_fall && rw) begin
                        tx_sh   <= reg_rd_data[6:0];
                        bit_cnt <= 3'd7;
                    end
                    RD_DATA: if (scl_fall && bit_cnt != 3'd0) begin
                        bit_cnt <= bit_cnt - 3'd1;
                        tx_sh   <= {tx_sh[5:0], 1'b0};
                    end
                    RD_ACK: begin
                        // The pointer advances on ACK and NACK alike
                        if (scl_rise) begin
                            ptr <= ptr + PTR_W'(1);
                            if (sda_s) ack_error <= 1'b1;
                        end
                        if (scl_fall) begin
                            tx_sh   <= reg_rd_data[6:0];
                            bit_cnt <= 3'd7;
                        end
                    end
                    WR_ACK: if (scl_fall) ptr <= ptr + PTR_W'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
- Parametrised I2C target (slave) with a byte-wide register-file back end.
- Supports multi-byte transfers with pointer auto-increment, repeated START, and START/STOP detection in any state.
- Sits between the open-drain I2C pins and a user register bank. It issues write strobes and read addresses; the register storage itself lives outside the block.

Parameters:
- TARGET_ADDR, 7'h01, 7-bit I2C address this target answers to.
- NUM_REGS, 16, register count; power of two, 2..256.
- PTR_W, $clog2(NUM_REGS), register pointer width (derived, not overridden).
- SYNC_STAGES, 2, synchroniser depth for SCL/SDA; at least 2.

Ports:
- clk_400  input  1  system clock; at least 8x SCL rate.
- rst_n  input  1  synchronous, active-low reset, sampled on clk_400.
- SCL  input  1  I2C clock from the controller.
- SDA  inout  1  I2C data; driven only low or high-Z (open drain).
- reg_wr_en  output  1  one-cycle write strobe to the register bank.
- reg_wr_addr  output  PTR_W  write address, valid with reg_wr_en.
- reg_wr_data  output  8  write data, valid with reg_wr_en.
- reg_rd_addr  output  PTR_W  current read pointer.
- reg_rd_data  input  8  register bank read data; combinational from reg_rd_addr.
- busy  output  1  high from an address match until STOP or NACK exit.
- done  output  1  one-cycle pulse on a STOP that ends an addressed transaction.
- ack_error  output  1  sticky; set when the controller NACKs a read byte, cleared at the next START.
- state_out  output  4  current FSM state, for debug.

Behaviour:
- Input conditioning:
  - SCL and SDA each pass through SYNC_STAGES flops, then a delay flop for edge detection.
  - scl_rise and scl_fall are one-cycle pulses.
  - START = synced SDA falls while synced SCL is high.
  - STOP = synced SDA rises while synced SCL is high.
- SDA drive: SDA is pulled low when sda_low=1, otherwise released to Z. sda_low is registered and changes only on the clk_400 cycle after scl_fall, or on START/STOP/reset (forced 0).
- Reset: every output is 0, SDA is released, pointer is 0, state is IDLE. A reset mid-transfer releases SDA on the next clock.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- Shifting: all receive states sample SDA MSB-first on scl_rise; the bit counter runs 7..0.
- START in any state (including repeated START): go to ADDR, clear the shift register and ack_error. busy and the pointer are unchanged.
- STOP in any state: go to IDLE and release SDA. If busy=1, drop busy and pulse done.
- ADDR: after 8 bits, compare byte[7:1] with TARGET_ADDR and latch rw = byte[0].
  - Match: drive ACK (SDA low) for the 9th bit, set busy, go to ADDR_ACK.
  - No match: leave SDA released (NACK) and go to WAIT_STOP.
- ADDR_ACK: on the scl_fall ending the ACK bit, go to RD_DATA if rw=1, else PTR.
- Entering RD_DATA: the byte is loaded from reg_rd_data on that same scl_fall, and bit 7 is presented at once.
- PTR: after 8 bits:
  - Value < NUM_REGS: load the pointer, ACK, go to PTR_ACK, then to WR_DATA on scl_fall.
  - Value >= NUM_REGS: NACK, pointer unchanged, go to WAIT_STOP.
- WR_DATA: after 8 bits, pulse reg_wr_en with reg_wr_addr = pointer and reg_wr_data = byte, within 2 clk_400 cycles of the 8th scl_rise. Then ACK and go to WR_ACK.
- WR_ACK: on scl_fall, pointer += 1 modulo NUM_REGS (wraps NUM_REGS-1 -> 0), then return to WR_DATA.
- RD_DATA: present the byte MSB first, changing SDA only after scl_fall. A data bit of 0 drives SDA low; a 1 releases it. After the 8th bit's scl_fall, release SDA and go to RD_ACK.
- RD_ACK: sample SDA on scl_rise.
  - 0 (ACK): pointer += 1 with wrap; on scl_fall, load the next byte and return to RD_DATA.
  - 1 (NACK): set ack_error and go to WAIT_STOP; the pointer still increments.
- WAIT_STOP: SDA released; leave only on START or STOP.
- reg_rd_addr always equals the pointer.
- The target never stretches SCL.
- A repeated-START read after a pointer write reads from the written pointer.

Test Plan:
- Write burst: S, 0x02, 0x03, 0xA5, 0x5A, P -> ACK on all 4 bytes; reg_wr_en pulses twice, at (3,0xA5) then (4,0x5A); done pulses once; busy=0 after P.
- Combined read with repeated START: registers [3]=0x11 and [4]=0x22. Send S, 0x02, 0x03, Sr, 0x03; the controller reads 2 bytes (ACK, then NACK), then P -> SDA bits are 0x11 then 0x22; ack_error=1 after the NACK; reg_rd_addr=5 at the end.
- Pointer wrap: NUM_REGS=16; write ptr 0x0F, then 0xAA, 0xBB -> writes (15,0xAA) then (0,0xBB).
- Address mismatch: S, 0x04 (address 0x02), data 0xFF, P -> SDA never driven low, no reg_wr_en, busy stays 0, no done.
- Illegal pointer: S, 0x02, 0x20 with NUM_REGS=16 -> ACK on the address, NACK on the pointer; pointer unchanged; subsequent bytes ignored until P.
- Reset mid-read: assert rst_n=0 during the 4th bit of RD_DATA while SDA is held low -> SDA is Z and state_out is IDLE next cycle; a fresh read S, 0x03 returns reg[0].
